// File: rtl/wb_b3_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and the burst RAM slave.
// Signals (master view): adr[31:0], bte[1:0], cti[2:0], cyc, stb, we,
//   sel[3:0], dat_w[31:0] out; dat_r[31:0], ack, err, rty in.
interface wb_b3_burst_master_if;
    logic [31:0] adr;
    logic [1:0]  bte;
    logic [2:0]  cti;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_w;   // master -> slave write data
    logic [31:0] dat_r;   // slave -> master read data
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, bte, cti, cyc, stb, we, sel, dat_w,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, bte, cti, cyc, stb, we, sel, dat_w,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 master: turns one request command into a single classic beat
// or a wrapping incrementing burst (critical word first) for cache-line
// refill/writeback against the on-chip burst RAM slave.
// Ports:
//   wb_clk_i, wb_rst_i (sync, active high)
//   req_valid_i/req_ready_o, req_we_i, req_single_i, req_adr_i, req_sel_i : command
//   wr_dat_i/wr_beat_o : write word stream, one word per acked beat
//   rd_dat_o/rd_valid_o : read word stream, one word per acked beat
//   done_o/err_o : end-of-transaction pulse, err_o marks an abort
//   wb : Wishbone B3 master modport
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYC cycles of stb high without an ack/err/rty.
module wb_b3_burst_master #(
    parameter int unsigned BEATS       = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic        req_single_i,
    input  logic [31:0] req_adr_i,
    input  logic [3:0]  req_sel_i,
    input  logic [31:0] wr_dat_i,
    output logic        wr_beat_o,
    output logic [31:0] rd_dat_o,
    output logic        rd_valid_o,
    output logic        done_o,
    output logic        err_o,
    wb_b3_burst_master_if.master wb
);
    localparam int unsigned OFF_W = $clog2(BEATS);
    localparam logic [1:0] BTE_BURST = (BEATS == 16) ? 2'b11 :
                                       (BEATS == 8)  ? 2'b10 : 2'b01;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t           state, state_n;
    logic             cyc, cyc_n, stb, stb_n, we, we_n, single, single_n;
    logic [2:0]       cti, cti_n;
    logic [1:0]       bte, bte_n;
    logic [31:0]      adr, adr_n;
    logic [3:0]       sel, sel_n;
    logic [OFF_W-1:0] beat, beat_n;
    logic             done, done_n, err, err_n;
    logic             acked, abort, beat_ok, tmo_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [7:0] tmo_cnt, tmo_cnt_n;

    // Counts stalled strobe cycles; any ack or leaving BUS clears it.
    always_comb begin
        tmo_cnt_n = '0;
        if (state == BUS && !wb.ack) tmo_cnt_n = tmo_cnt + 8'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) tmo_cnt <= '0;
        else          tmo_cnt <= tmo_cnt_n;
    end

    assign tmo_hit = stb & ~wb.ack & (tmo_cnt == 8'(TIMEOUT_CYC - 1));

    logic unused_ok;
    assign unused_ok = &{1'b0, req_adr_i[1:0]};
`else
    assign tmo_hit = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, req_adr_i[1:0], 8'(TIMEOUT_CYC)};
`endif

    // An ack only counts while strobing; err/rty/timeout override a same-cycle ack.
    assign acked   = wb.ack & stb;
    assign abort   = (stb & (wb.err | wb.rty)) | tmo_hit;
    assign beat_ok = acked & ~abort;

    // Next-state and registered-output logic.
    always_comb begin
        state_n  = state;
        cyc_n    = cyc;
        stb_n    = stb;
        we_n     = we;
        single_n = single;
        cti_n    = cti;
        bte_n    = bte;
        adr_n    = adr;
        sel_n    = sel;
        beat_n   = beat;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    state_n  = BUS;
                    cyc_n    = 1'b1;
                    stb_n    = 1'b1;
                    we_n     = req_we_i;
                    single_n = req_single_i;
                    beat_n   = '0;
                    adr_n    = {req_adr_i[31:2], 2'b00};
                    if (req_single_i) begin
                        cti_n = CTI_CLASSIC;
                        bte_n = BTE_LINEAR;
                        sel_n = req_sel_i;
                    end else begin
                        cti_n = CTI_INCR;
                        bte_n = BTE_BURST;
                        sel_n = 4'hf;
                    end
                end
            end
            BUS: begin
                if (abort) begin
                    state_n = DONE;
                    cyc_n   = 1'b0;
                    stb_n   = 1'b0;
                    cti_n   = CTI_CLASSIC;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                end else if (acked) begin
                    if (single || beat == LAST_BEAT) begin
                        state_n = DONE;
                        cyc_n   = 1'b0;
                        stb_n   = 1'b0;
                        cti_n   = CTI_CLASSIC;
                        done_n  = 1'b1;
                    end else begin
                        beat_n = beat + OFF_W'(1);
                        // Offset field wraps inside the line; base bits untouched.
                        adr_n[OFF_W+1:2] = adr[OFF_W+1:2] + OFF_W'(1);
                        cti_n  = (beat_n == LAST_BEAT) ? CTI_END : CTI_INCR;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            cyc    <= 1'b0;
            stb    <= 1'b0;
            we     <= 1'b0;
            single <= 1'b0;
            cti    <= CTI_CLASSIC;
            bte    <= BTE_LINEAR;
            adr    <= '0;
            sel    <= '0;
            beat   <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cyc    <= cyc_n;
            stb    <= stb_n;
            we     <= we_n;
            single <= single_n;
            cti    <= cti_n;
            bte    <= bte_n;
            adr    <= adr_n;
            sel    <= sel_n;
            beat   <= beat_n;
            done   <= done_n;
            err    <= err_n;
        end
    end

    assign req_ready_o = (state == IDLE);
    assign rd_valid_o  = beat_ok & ~we;
    assign wr_beat_o   = beat_ok & we;
    assign rd_dat_o    = wb.dat_r;
    assign done_o      = done;
    assign err_o       = err;

    assign wb.cyc   = cyc;
    assign wb.stb   = stb;
    assign wb.we    = we;
    assign wb.cti   = cti;
    assign wb.bte   = bte;
    assign wb.adr   = adr;
    assign wb.sel   = sel;
    assign wb.dat_w = wr_dat_i;
endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Scoreboard bench for wb_b3_burst_master: a 4-beat instance with a burst RAM
// slave model (ack/err injection) and an 8-beat instance for the write burst.
module tb_wb_b3_burst_master;
    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] adr, input logic [2:0] cti,
                                 input logic [1:0] bte, input logic [3:0] sel,
                                 input logic we, input logic [31:0] dat);
        beat_t b;
        b.adr = adr; b.cti = cti; b.bte = bte; b.sel = sel; b.we = we; b.dat = dat;
        return b;
    endfunction

    // ---------------- 4-beat DUT + slave ----------------
    logic        req_valid4, req_ready4, req_we4, req_single4;
    logic [31:0] req_adr4, wr_dat4, rd_dat4;
    logic [3:0]  req_sel4;
    logic        wr_beat4, rd_valid4, done4, err4;
    wb_b3_burst_master_if wb4();

    wb_b3_burst_master #(.BEATS(4), .TIMEOUT_CYC(16)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid_i(req_valid4), .req_ready_o(req_ready4),
        .req_we_i(req_we4), .req_single_i(req_single4),
        .req_adr_i(req_adr4), .req_sel_i(req_sel4),
        .wr_dat_i(wr_dat4), .wr_beat_o(wr_beat4),
        .rd_dat_o(rd_dat4), .rd_valid_o(rd_valid4),
        .done_o(done4), .err_o(err4), .wb(wb4)
    );

    logic [31:0] mem4 [0:255];
    bit ack_en4 = 1'b1;
    int err_at4 = -1;
    int sbeat4  = 0;

    assign wb4.ack   = wb4.cyc & wb4.stb & ack_en4;
    assign wb4.err   = wb4.cyc & wb4.stb & (sbeat4 == err_at4);
    assign wb4.rty   = 1'b0;
    assign wb4.dat_r = mem4[wb4.adr[9:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem4[i] <= 32'h1000_0000 + 32'(i);
            sbeat4 <= 0;
        end else begin
            if (!wb4.cyc) sbeat4 <= 0;
            else if (wb4.stb && wb4.ack) sbeat4 <= sbeat4 + 1;
            if (wb4.cyc && wb4.stb && wb4.ack && wb4.we && !wb4.err)
                for (int b = 0; b < 4; b++)
                    if (wb4.sel[b]) mem4[wb4.adr[9:2]][8*b +: 8] <= wb4.dat_w[8*b +: 8];
        end
    end

    // ---------------- 8-beat DUT + slave ----------------
    logic        req_valid8, req_ready8, wr_beat8, rd_valid8, done8, err8;
    logic [31:0] wr_dat8, unused_rd_dat8, k8;
    wb_b3_burst_master_if wb8();

    wb_b3_burst_master #(.BEATS(8), .TIMEOUT_CYC(16)) u_dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid_i(req_valid8), .req_ready_o(req_ready8),
        .req_we_i(1'b1), .req_single_i(1'b0),
        .req_adr_i(32'h0000_0200), .req_sel_i(4'hf),
        .wr_dat_i(wr_dat8), .wr_beat_o(wr_beat8),
        .rd_dat_o(unused_rd_dat8), .rd_valid_o(rd_valid8),
        .done_o(done8), .err_o(err8), .wb(wb8)
    );

    logic [31:0] mem8 [0:255];
    assign wb8.ack   = wb8.cyc & wb8.stb;
    assign wb8.err   = 1'b0;
    assign wb8.rty   = 1'b0;
    assign wb8.dat_r = mem8[wb8.adr[9:2]];

    // Requester side: present word k on beat k, advance after each accepted beat.
    always @(posedge clk) begin
        if (rst) k8 <= '0;
        else if (wr_beat8) k8 <= k8 + 32'd1;
        if (!rst && wb8.cyc && wb8.stb && wb8.ack && wb8.we) mem8[wb8.adr[9:2]] <= wb8.dat_w;
    end
    assign wr_dat8 = k8;

    // ---------------- scoreboards ----------------
    beat_t      q4[$];
    beat_t      q8[$];
    logic [1:0] qd4[$];   // {err, must follow a terminating bus cycle}
    logic [1:0] qd8[$];
    bit         prev_hit4 = 1'b0;
    int         nb8 = 0;

    always @(negedge clk) begin
        beat_t      e;
        logic [1:0] d;
        if (rd_valid4 === 1'b1 || wr_beat4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL beat4_unexpected: got beat at adr %h expected none", wb4.adr);
            end else begin
                e = q4.pop_front();
                chk("beat4_adr", wb4.adr, e.adr);
                chk("beat4_cti", 32'(wb4.cti), 32'(e.cti));
                chk("beat4_bte", 32'(wb4.bte), 32'(e.bte));
                chk("beat4_sel", 32'(wb4.sel), 32'(e.sel));
                chk("beat4_we",  32'(wb4.we),  32'(e.we));
                chk("beat4_dat", e.we ? wb4.dat_w : rd_dat4, e.dat);
            end
        end
        if (done4 === 1'b1) begin
            if (qd4.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL done4_unexpected: got done_o=1 expected 0");
            end else begin
                d = qd4.pop_front();
                chk("done4_err", 32'(err4), 32'(d[1]));
                chk("done4_cyc_low", 32'(wb4.cyc), 32'd0);
                if (d[0]) chk("done4_after_term", 32'(prev_hit4), 32'd1);
            end
        end
        prev_hit4 = (wb4.stb === 1'b1) && (wb4.ack === 1'b1 || wb4.err === 1'b1);
    end

    always @(negedge clk) begin
        beat_t      e;
        logic [1:0] d;
        if (rd_valid8 === 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL rd_valid8: got 1 expected 0");
        end
        if (wr_beat8 === 1'b1) begin
            nb8++;
            if (q8.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL beat8_unexpected: got beat at adr %h expected none", wb8.adr);
            end else begin
                e = q8.pop_front();
                chk("beat8_adr", wb8.adr, e.adr);
                chk("beat8_cti", 32'(wb8.cti), 32'(e.cti));
                chk("beat8_bte", 32'(wb8.bte), 32'(e.bte));
                chk("beat8_sel", 32'(wb8.sel), 32'(e.sel));
                chk("beat8_dat", wb8.dat_w, e.dat);
            end
        end
        if (done8 === 1'b1) begin
            if (qd8.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL done8_unexpected: got done_o=1 expected 0");
            end else begin
                d = qd8.pop_front();
                chk("done8_err", 32'(err8), 32'(d[1]));
                chk("done8_cyc_low", 32'(wb8.cyc), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue4(input logic we, input logic single,
                          input logic [31:0] adr, input logic [3:0] sel);
        int n = 0;
        while (req_ready4 !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("issue4_ready", 32'(req_ready4), 32'd1);
        req_we4 = we; req_single4 = single; req_adr4 = adr; req_sel4 = sel;
        req_valid4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
    endtask

    task automatic wait_done4(input string name, input int budget);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (done4 === 1'b1) seen = 1'b1;
            n++;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: got no done_o in %0d cycles expected done_o", name, budget);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        rst = 1'b1;
        req_valid4 = 1'b0; req_we4 = 1'b0; req_single4 = 1'b0;
        req_adr4 = '0; req_sel4 = '0; wr_dat4 = '0;
        req_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cyc",   32'(wb4.cyc), 32'd0);
        chk("rst_stb",   32'(wb4.stb), 32'd0);
        chk("rst_we",    32'(wb4.we),  32'd0);
        chk("rst_cti",   32'(wb4.cti), 32'd0);
        chk("rst_bte",   32'(wb4.bte), 32'd0);
        chk("rst_adr",   wb4.adr,      32'd0);
        chk("rst_sel",   32'(wb4.sel), 32'd0);
        chk("rst_done",  32'(done4),   32'd0);
        chk("rst_err",   32'(err4),    32'd0);
        chk("rst_ready", 32'(req_ready4), 32'd1);
        chk("rst_ready8", 32'(req_ready8), 32'd1);
        @(posedge clk); #1;

        // 1: 4-beat read, critical word 0x108, wraps within the 16-byte line
        q4.push_back(mk(32'h108, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0042));
        q4.push_back(mk(32'h10C, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0043));
        q4.push_back(mk(32'h100, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0040));
        q4.push_back(mk(32'h104, 3'b111, 2'b01, 4'hf, 1'b0, 32'h1000_0041));
        qd4.push_back(2'b01);
        issue4(1'b0, 1'b0, 32'h0000_0108, 4'hf);
        wait_done4("t1", 50);
        chk("t1_beats_left", 32'(q4.size()), 32'd0);

        // 2: 8-beat write at 0x200, word k on beat k
        for (int k = 0; k < 8; k++)
            q8.push_back(mk(32'h200 + 32'(4*k), (k == 7) ? 3'b111 : 3'b010,
                            2'b10, 4'hf, 1'b1, 32'(k)));
        qd8.push_back(2'b01);
        req_valid8 = 1'b1;
        @(posedge clk); #1;
        req_valid8 = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            if (done8 === 1'b1) seen = 1'b1;
            n++;
        end
        chk("t2_done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        chk("t2_beat_pulses", 32'(nb8), 32'd8);
        for (int k = 0; k < 8; k++) chk("t2_mem", mem8[8'h80 + 8'(k)], 32'(k));

        // 3: single write, only byte lane 1 enabled
        wr_dat4 = 32'hAABB_CCDD;
        q4.push_back(mk(32'h010, 3'b000, 2'b00, 4'b0010, 1'b1, 32'hAABB_CCDD));
        qd4.push_back(2'b01);
        issue4(1'b1, 1'b1, 32'h0000_0010, 4'b0010);
        wait_done4("t3", 20);
        chk("t3_mem_word", mem4[4], 32'h1000_CC04);

        // 4: err on third beat (acked together with err) aborts, 2 words delivered
        err_at4 = 2;
        q4.push_back(mk(32'h100, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0040));
        q4.push_back(mk(32'h104, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0041));
        qd4.push_back(2'b11);
        issue4(1'b0, 1'b0, 32'h0000_0100, 4'hf);
        wait_done4("t4", 50);
        err_at4 = -1;
        chk("t4_beats_left", 32'(q4.size()), 32'd0);

        // 5: reset during beat 1, then a normal burst
        q4.push_back(mk(32'h100, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0040));
        q4.push_back(mk(32'h104, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0041));
        issue4(1'b0, 1'b0, 32'h0000_0100, 4'hf);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_cyc",   32'(wb4.cyc), 32'd0);
        chk("t5_stb",   32'(wb4.stb), 32'd0);
        chk("t5_ready", 32'(req_ready4), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_beats_left", 32'(q4.size()), 32'd0);
        q4.push_back(mk(32'h10C, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0043));
        q4.push_back(mk(32'h100, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0040));
        q4.push_back(mk(32'h104, 3'b010, 2'b01, 4'hf, 1'b0, 32'h1000_0041));
        q4.push_back(mk(32'h108, 3'b111, 2'b01, 4'hf, 1'b0, 32'h1000_0042));
        qd4.push_back(2'b01);
        issue4(1'b0, 1'b0, 32'h0000_010C, 4'hf);
        wait_done4("t5", 50);
        chk("t5_new_beats_left", 32'(q4.size()), 32'd0);

        // 6: slave never acks
        ack_en4 = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        qd4.push_back(2'b10);
        issue4(1'b0, 1'b0, 32'h0000_0100, 4'hf);
        n = 0;
        while (wb4.cyc === 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("t6_timeout_cycles", 32'(n), 32'd16);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_done_left", 32'(qd4.size()), 32'd0);
`else
        issue4(1'b0, 1'b0, 32'h0000_0100, 4'hf);
        repeat (40) @(posedge clk);
        #1;
        chk("t6_cyc_held",  32'(wb4.cyc), 32'd1);
        chk("t6_stb_held",  32'(wb4.stb), 32'd1);
        chk("t6_not_ready", 32'(req_ready4), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        ack_en4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("end_q4",  32'(q4.size()),  32'd0);
        chk("end_qd4", 32'(qd4.size()), 32'd0);
        chk("end_q8",  32'(q8.size()),  32'd0);
        chk("end_qd8", 32'(qd8.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
